// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing the single access port of the 4x8 register file.
// Optional lock feature (atomic RMW runs) enabled by defining REGARB_LOCK_EN.
module regfile_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 2,
   parameter int MAX_LOCK = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        we,
   input  logic [NUM_REQ*ADDR_W-1:0] addr_a,
   input  logic [NUM_REQ*ADDR_W-1:0] addr_b,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
   input  logic [NUM_REQ-1:0]        lock,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rdata_a,
   output logic [DATA_W-1:0]         rdata_b,
   output logic                      busy,
   output logic [ADDR_W-1:0]         rf_ra_addr,
   output logic [ADDR_W-1:0]         rf_rb_addr,
   output logic                      rf_write,
   output logic [DATA_W-1:0]         rf_data_in,
   input  logic [DATA_W-1:0]         rf_rega,
   input  logic [DATA_W-1:0]         rf_regb
);

   localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_ptr;
   logic [IDX_W-1:0]    r_gnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr_a;
   logic [ADDR_W-1:0]   r_addr_b;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata_a;
   logic [DATA_W-1:0]   r_rdata_b;

   logic [NUM_REQ-1:0]  w_gnt_oh;
   logic [NUM_REQ-1:0]  w_cand;
   logic [IDX_W-1:0]    w_idx;
   logic [IDX_W-1:0]    w_sel;
   logic [IDX_W-1:0]    w_pick;
   logic [IDX_W-1:0]    w_ptr_nxt;
   logic                w_hit;
   logic                w_relock;
   logic                w_grant;
   logic                w_pl_we;
   logic [ADDR_W-1:0]   w_pl_addr_a;
   logic [ADDR_W-1:0]   w_pl_addr_b;
   logic [DATA_W-1:0]   w_pl_wdata;

   assign w_gnt_oh   = NUM_REQ'(1) << r_gnt;
   assign w_ptr_nxt  = (r_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
   assign w_pick     = w_relock ? r_gnt : w_sel;
   assign w_grant    = w_hit | w_relock;

   assign rdata_a    = r_rdata_a;
   assign rdata_b    = r_rdata_b;
   assign rf_ra_addr = r_addr_a;
   assign rf_rb_addr = r_addr_b;
   assign rf_data_in = r_wdata;

`ifdef REGARB_LOCK_EN
   localparam int LCNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;

   logic [LCNT_W-1:0] r_lcnt;

   assign w_relock = (r_state == S_DONE) && lock[r_gnt] && req[r_gnt] &&
                     (r_lcnt < LCNT_W'(MAX_LOCK - 1));

   // Count consecutive re-grants to the locking requester; any release clears it
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lcnt <= '0;
      end else if (r_state == S_DONE) begin
         r_lcnt <= w_relock ? r_lcnt + 1'b1 : '0;
      end
   end
`else
   logic w_unused_lock;

   assign w_relock      = 1'b0;
   assign w_unused_lock = (^lock) | (MAX_LOCK == 0);
`endif

   // Eligible requesters: all in IDLE; in DONE the one just served is still high, so mask it
   always_comb begin
      w_cand = '0;
      if (r_state == S_IDLE) begin
         w_cand = req;
      end else if (r_state == S_DONE) begin
         w_cand = req & ~w_gnt_oh;
      end
   end

   // Round-robin scan: first eligible bit from the pointer upward, wrapping
   always_comb begin
      w_hit = 1'b0;
      w_sel = r_ptr;
      w_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
         if (!w_hit && w_cand[w_idx]) begin
            w_hit = 1'b1;
            w_sel = w_idx;
         end
      end
   end

   // Payload mux for the requester being granted
   always_comb begin
      w_pl_we     = 1'b0;
      w_pl_addr_a = '0;
      w_pl_addr_b = '0;
      w_pl_wdata  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_pick == IDX_W'(k)) begin
            w_pl_we     = we[k];
            w_pl_addr_a = addr_a[k*ADDR_W +: ADDR_W];
            w_pl_addr_b = addr_b[k*ADDR_W +: ADDR_W];
            w_pl_wdata  = wdata[k*DATA_W +: DATA_W];
         end
      end
   end

   // Next state and state-decoded outputs
   always_comb begin
      w_state_nxt = r_state;
      ack         = '0;
      busy        = 1'b0;
      rf_write    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_grant) w_state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            busy        = 1'b1;
            rf_write    = r_we;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            busy        = 1'b1;
            ack         = w_gnt_oh;
            w_state_nxt = w_grant ? S_ACCESS : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, latched payload, captured read data and rotating pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_gnt     <= '0;
         r_we      <= 1'b0;
         r_addr_a  <= '0;
         r_addr_b  <= '0;
         r_wdata   <= '0;
         r_rdata_a <= '0;
         r_rdata_b <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_gnt    <= w_pick;
            r_we     <= w_pl_we;
            r_addr_a <= w_pl_addr_a;
            r_addr_b <= w_pl_addr_b;
            r_wdata  <= w_pl_wdata;
         end
         if (r_state == S_ACCESS) begin
            r_rdata_a <= rf_rega;
            r_rdata_b <= rf_regb;
            r_ptr     <= w_ptr_nxt;
         end
      end
   end

endmodule
